// File: rtl/pc_gen.sv
// Program counter generator: IDLE/RUN fetch FSM with redirect, stall and wrap.
// Define PC_MISALIGN_TRAP_EN to trap misaligned redirects to TRAP_VECTOR.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc,
    output logic            valid
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    logic [XLEN-1:0] load_pc;

    if (XLEN < 16 || XLEN > 64) begin : g_bad_xlen
        $error("pc_gen: XLEN out of range");
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic bad_align;
    assign bad_align = |redirect_target[1:0];
    assign load_pc   = bad_align ? TRAP_VECTOR : redirect_target;
`else
    // Low target bits are dropped; instructions are always word aligned.
    logic unused_bits;
    assign unused_bits = ^{TRAP_VECTOR, redirect_target[1:0]};
    assign load_pc     = {redirect_target[XLEN-1:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            valid    <= 1'b1;
            pc       <= RESET_VECTOR;
`ifdef PC_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_TRAP_EN
            misalign <= redirect_valid && bad_align;
`endif
            // A redirect overrides everything but never changes state.
            if (redirect_valid) begin
                pc <= load_pc;
            end else begin
                unique case (state)
                    RUN: begin
                        if (ready) begin
                            pc <= pc + XLEN'(4);
                        end
                        if (!en) begin
                            state <= IDLE;
                            valid <= 1'b0;
                        end
                    end
                    IDLE: begin
                        if (en) begin
                            state <= RUN;
                            valid <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic
// checked against a behavioural fetch model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic        valid;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mpc;
    logic        mvalid;
    logic        mmis;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0),
        .TRAP_VECTOR (32'h100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .ready          (ready),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .pc             (pc),
        .valid          (valid)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign       (misalign)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        mpc    = 32'h0;
        mvalid = 1'b1;
        mmis   = 1'b0;
    endtask

    // Fetch-level view: redirect loads a word address, an accepted request
    // advances one word, en only controls whether requests are presented.
    task automatic model_step(input logic e, input logic r, input logic rv,
                              input logic [31:0] t);
        mmis = 1'b0;
        if (rv) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (t % 4 != 0) begin
                mpc  = 32'h100;
                mmis = 1'b1;
            end else begin
                mpc = t;
            end
`else
            mpc = t - (t % 4);
`endif
        end else if (mvalid) begin
            if (r) mpc = 32'((64'(mpc) + 4) % 64'h1_0000_0000);
            if (!e) mvalid = 1'b0;
        end else if (e) begin
            mvalid = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("pc", 64'(pc), 64'(mpc));
        chk("valid", 64'(valid), 64'(mvalid));
`ifdef PC_MISALIGN_TRAP_EN
        chk("misalign", 64'(misalign), 64'(mmis));
`endif
    endtask

    task automatic cyc(input logic e, input logic r, input logic rv,
                       input logic [31:0] t);
        en              = e;
        ready           = r;
        redirect_valid  = rv;
        redirect_target = t;
        @(posedge clk);
        model_step(e, r, rv, t);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst             = 1'b0;
        en              = 1'b0;
        ready           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        model_reset();
        #12;
        chk("reset_pc", 64'(pc), 64'h0);
        chk("reset_valid", 64'(valid), 64'h1);
`ifdef PC_MISALIGN_TRAP_EN
        chk("reset_misalign", 64'(misalign), 64'h0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Reset vector fetched, then sequential advance.
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 1, 0, 0);
            chk("seq", 64'(pc), 64'(4 * i));
        end

        // Stall at 0x10 for three cycles, then accept.
        cyc(1, 0, 1, 32'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            chk("stall", 64'(pc), 64'h10);
        end
        cyc(1, 1, 0, 0);
        chk("stall_release", 64'(pc), 64'h14);

        // Redirect while stalled drops the old PC.
        cyc(1, 0, 1, 32'h10);
        cyc(1, 0, 1, 32'h200);
        chk("redir_pc", 64'(pc), 64'h200);
        chk("redir_valid", 64'(valid), 64'h1);
        cyc(1, 1, 0, 0);
        chk("redir_next", 64'(pc), 64'h204);

        // Back-to-back redirects: last one wins.
        cyc(1, 1, 1, 32'h400);
        cyc(1, 1, 1, 32'h500);
        chk("b2b", 64'(pc), 64'h500);

        // Wrap at top of address space.
        cyc(1, 0, 1, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0);
        chk("wrap", 64'(pc), 64'h0);

        // Idle entry, redirect while idle, resume without increment.
        cyc(1, 0, 1, 32'h20);
        cyc(0, 0, 0, 0);
        chk("idle_valid", 64'(valid), 64'h0);
        chk("idle_pc", 64'(pc), 64'h20);
        cyc(0, 1, 1, 32'h80);
        chk("idle_redir_pc", 64'(pc), 64'h80);
        chk("idle_redir_valid", 64'(valid), 64'h0);
        cyc(1, 1, 0, 0);
        chk("resume_pc", 64'(pc), 64'h80);
        chk("resume_valid", 64'(valid), 64'h1);

        // en=0 with handshake on the same edge.
        cyc(0, 1, 0, 0);
        chk("en0_hs_pc", 64'(pc), 64'h84);
        chk("en0_hs_valid", 64'(valid), 64'h0);
        cyc(1, 0, 0, 0);

        // Misaligned redirect target.
        cyc(1, 0, 1, 32'h103);
        chk("misal_pc", 64'(pc), 64'h100);
`ifdef PC_MISALIGN_TRAP_EN
        chk("misal_pulse", 64'(misalign), 64'h1);
        cyc(1, 0, 0, 0);
        chk("misal_drop", 64'(misalign), 64'h0);
`endif

        // Asynchronous reset in the middle of a stall.
        cyc(1, 0, 1, 32'h340);
        #2;
        rst = 1'b0;
        #1;
        chk("async_pc", 64'(pc), 64'h0);
        chk("async_valid", 64'(valid), 64'h1);
        model_reset();
        @(negedge clk);
        check_model();
        rst = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, $urandom % 2 == 1,
                ($urandom % 8) == 0,
                $urandom_range(0, 255) == 0 ? 32'hFFFF_FFFC : $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
